spmm_csr: RTL and testbench

Sparse-matrix × sparse-matrix multiplier C = A·B, with all three matrices in CSR form (values NV, column indices CI, row pointers RP). It is the top-level compute block. Input CSR arrays arrive as flat packed vectors, and the result CSR arrays are driven as registered packed vectors. It uses a row-wise Gustavson algorithm with a one-row dense accumulator and performs one multiply-accumulate per clock.

---
 rtl/spmm_pkg.sv | 18 +
 rtl/spmm_row_acc.sv | 47 ++++
 rtl/spmm_csr.sv | 151 +++++++++++++++
 tb/tb_spmm_csr.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/spmm_pkg.sv
// Shared defaults, FSM state encoding and element typedefs for the CSR sparse-matrix multiplier.
package spmm_pkg;
    localparam int DW_DEFAULT = 32;
    localparam int M_DEFAULT  = 16;
    localparam int IW_DEFAULT = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ROW_INIT,
        S_A_FETCH,
        S_MAC,
        S_EMIT,
        S_DONE
    } state_t;

    typedef logic [DW_DEFAULT-1:0] val_t;
    typedef logic [IW_DEFAULT-1:0] idx_t;
endpackage

// File: rtl/spmm_row_acc.sv
// One-row dense accumulator with per-column valid flags and a lowest-flag pop port.
module spmm_row_acc
    import spmm_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int M  = M_DEFAULT,
    parameter int IW = IW_DEFAULT
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_clr,
    input  logic          i_acc_en,
    input  logic [IW-1:0] i_acc_col,
    input  logic [DW-1:0] i_acc_add,
    input  logic          i_pop,
    output logic          o_any,
    output logic [IW-1:0] o_pop_col,
    output logic [DW-1:0] o_pop_val
);
    logic [DW-1:0] r_val [M];
    logic [M-1:0]  r_flag;
    logic [IW-1:0] w_col;

    // Scanning downward leaves the lowest flagged column selected.
    always_comb begin
        w_col = '0;
        for (int c = M - 1; c >= 0; c--) begin
            if (r_flag[c]) w_col = IW'(c);
        end
        o_any     = |r_flag;
        o_pop_col = w_col;
        o_pop_val = r_val[w_col];
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_flag <= '0;
            for (int c = 0; c < M; c++) r_val[c] <= '0;
        end else begin
            if (i_acc_en) begin
                r_val[i_acc_col]  <= r_val[i_acc_col] + i_acc_add;
                r_flag[i_acc_col] <= 1'b1;
            end
            if (i_pop) r_flag[w_col] <= 1'b0;
        end
    end
endmodule

// File: rtl/spmm_csr.sv
// CSR x CSR sparse matrix multiplier, row-wise Gustavson with one MAC per clock.
module spmm_csr
    import spmm_pkg::*;
#(
    parameter int data_width_param   = DW_DEFAULT,
    parameter int max_elements_param = M_DEFAULT,
    parameter int idx_width_param    = IW_DEFAULT
) (
    input  logic                                                  clk_i,
    input  logic                                                  rst_i,
    input  logic                                                  start_i,
    input  logic [idx_width_param-1:0]                            rows_A_i,
    input  logic [0:max_elements_param-1][data_width_param-1:0]   NVA_i,
    input  logic [0:max_elements_param-1][idx_width_param-1:0]    CIA_i,
    input  logic [0:max_elements_param-1][idx_width_param-1:0]    RPA_i,
    input  logic [0:max_elements_param-1][data_width_param-1:0]   NVB_i,
    input  logic [0:max_elements_param-1][idx_width_param-1:0]    CIB_i,
    input  logic [0:max_elements_param-1][idx_width_param-1:0]    RPB_i,
    output logic [0:max_elements_param-1][data_width_param-1:0]   NVC_o,
    output logic [0:max_elements_param-1][idx_width_param-1:0]    CIC_o,
    output logic [0:max_elements_param-1][idx_width_param-1:0]    RPC_o,
    output logic                                                  computing_o,
    output logic                                                  op_complete_o
);
    localparam int DW = data_width_param;
    localparam int M  = max_elements_param;
    localparam int IW = idx_width_param;

    state_t                  r_state;
    logic [IW-1:0]           r_row, r_k, r_j, r_l, r_p;
    logic [DW-1:0]           r_a;
    logic [0:M-1][DW-1:0]    r_nvc;
    logic [0:M-1][IW-1:0]    r_cic, r_rpc;
    logic                    r_computing, r_done;

    logic [IW-1:0] w_row_p1, w_k_p1, w_l_p1, w_j_fetch, w_rpb_lo, w_rpb_hi, w_rpb_end, w_rpa_end;
    logic [IW-1:0] w_acc_col, w_pop_col;
    logic [DW-1:0] w_acc_add, w_pop_val;
    logic          w_any;

    assign w_row_p1  = r_row + IW'(1);
    assign w_k_p1    = r_k + IW'(1);
    assign w_l_p1    = r_l + IW'(1);
    assign w_rpa_end = RPA_i[w_row_p1];
    assign w_j_fetch = CIA_i[r_k];
    assign w_rpb_lo  = RPB_i[w_j_fetch];
    assign w_rpb_hi  = RPB_i[w_j_fetch + IW'(1)];
    assign w_rpb_end = RPB_i[r_j + IW'(1)];
    assign w_acc_col = CIB_i[r_l];
    assign w_acc_add = r_a * NVB_i[r_l];

    spmm_row_acc #(.DW(DW), .M(M), .IW(IW)) u_acc (
        .i_clk     (clk_i),
        .i_rst     (rst_i),
        .i_clr     (r_state == S_ROW_INIT),
        .i_acc_en  (r_state == S_MAC),
        .i_acc_col (w_acc_col),
        .i_acc_add (w_acc_add),
        .i_pop     ((r_state == S_EMIT) && w_any),
        .o_any     (w_any),
        .o_pop_col (w_pop_col),
        .o_pop_val (w_pop_val)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= S_IDLE;
            r_row       <= '0;
            r_k         <= '0;
            r_j         <= '0;
            r_l         <= '0;
            r_p         <= '0;
            r_a         <= '0;
            r_nvc       <= '0;
            r_cic       <= '0;
            r_rpc       <= '0;
            r_computing <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        r_nvc <= '0;
                        r_cic <= '0;
                        r_rpc <= '0;
                        r_row <= '0;
                        r_p   <= '0;
                        if (rows_A_i != '0) begin
                            r_state     <= S_ROW_INIT;
                            r_computing <= 1'b1;
                            r_done      <= 1'b0;
                        end else begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                S_ROW_INIT: begin
                    r_k     <= RPA_i[r_row];
                    r_state <= (RPA_i[r_row] == w_rpa_end) ? S_EMIT : S_A_FETCH;
                end
                S_A_FETCH: begin
                    r_a <= NVA_i[r_k];
                    r_j <= w_j_fetch;
                    r_l <= w_rpb_lo;
                    // An empty B row contributes nothing, so skip straight to the next A entry.
                    if (w_rpb_lo == w_rpb_hi) begin
                        r_k <= w_k_p1;
                        if (w_k_p1 == w_rpa_end) r_state <= S_EMIT;
                    end else begin
                        r_state <= S_MAC;
                    end
                end
                S_MAC: begin
                    r_l <= w_l_p1;
                    if (w_l_p1 == w_rpb_end) begin
                        r_k     <= w_k_p1;
                        r_state <= (w_k_p1 == w_rpa_end) ? S_EMIT : S_A_FETCH;
                    end
                end
                S_EMIT: begin
                    if (w_any) begin
                        // The last slot is never filled; overflow entries are dropped.
                        if (r_p != IW'(M - 1)) begin
                            r_nvc[r_p] <= w_pop_val;
                            r_cic[r_p] <= w_pop_col;
                            r_p        <= r_p + IW'(1);
                        end
                    end else begin
                        r_rpc[w_row_p1] <= r_p;
                        r_row           <= w_row_p1;
                        if (w_row_p1 < rows_A_i) begin
                            r_state <= S_ROW_INIT;
                        end else begin
                            r_state     <= S_DONE;
                            r_computing <= 1'b0;
                            r_done      <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign NVC_o         = r_nvc;
    assign CIC_o         = r_cic;
    assign RPC_o         = r_rpc;
    assign computing_o   = r_computing;
    assign op_complete_o = r_done;
endmodule

// File: tb/tb_spmm_csr.sv
// Directed and randomized bench for spmm_csr against a dense row-by-row reference of C = A*B.
module tb_spmm_csr;
    logic              clk = 1'b0;
    logic              rst, start;
    logic [3:0]        rows_a;
    logic [0:15][31:0] nva, nvb;
    logic [0:15][3:0]  cia, rpa, cib, rpb;
    logic [0:15][31:0] nvc;
    logic [0:15][3:0]  cic, rpc;
    logic              computing, op_complete;

    int total = 0;
    int bad   = 0;
    int lat;
    bit prevc;

    logic [31:0] exp_nv [16];
    logic [3:0]  exp_ci [16];
    logic [3:0]  exp_rp [16];

    int m_nva [7] = '{1, 5, 7, 9, 4, 2, 6};
    int m_cia [7] = '{2, 1, 2, 0, 3, 0, 1};
    int m_rpa [5] = '{0, 1, 3, 5, 7};
    int m_nvb [8] = '{1, 3, 1, 2, 2, 1, 5, 7};
    int m_cib [8] = '{0, 2, 3, 0, 2, 1, 2, 3};
    int m_rpb [5] = '{0, 3, 3, 5, 8};
    int e_nv [11] = '{2, 2, 14, 14, 9, 4, 47, 37, 2, 6, 2};
    int e_ci [11] = '{0, 2, 0, 2, 0, 1, 2, 3, 0, 2, 3};
    int e_rp [5]  = '{0, 2, 4, 8, 11};

    spmm_csr dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .start_i       (start),
        .rows_A_i      (rows_a),
        .NVA_i         (nva),
        .CIA_i         (cia),
        .RPA_i         (rpa),
        .NVB_i         (nvb),
        .CIB_i         (cib),
        .RPB_i         (rpb),
        .NVC_o         (nvc),
        .CIC_o         (cic),
        .RPC_o         (rpc),
        .computing_o   (computing),
        .op_complete_o (op_complete)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int idx, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, idx, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 16; i++) begin
            check({tag, ".nvc"}, i, nvc[i], exp_nv[i]);
            check({tag, ".cic"}, i, {28'd0, cic[i]}, {28'd0, exp_ci[i]});
            check({tag, ".rpc"}, i, {28'd0, rpc[i]}, {28'd0, exp_rp[i]});
        end
    endtask

    task automatic clear_exp();
        for (int i = 0; i < 16; i++) begin
            exp_nv[i] = '0;
            exp_ci[i] = '0;
            exp_rp[i] = '0;
        end
    endtask

    task automatic load_main_a();
        nva = '0; cia = '0; rpa = '0;
        for (int i = 0; i < 7; i++) begin
            nva[i] = m_nva[i];
            cia[i] = m_cia[i][3:0];
        end
        for (int i = 0; i < 16; i++) rpa[i] = (i < 5) ? m_rpa[i][3:0] : 4'd7;
        rows_a = 4'd4;
    endtask

    task automatic load_main_b();
        nvb = '0; cib = '0; rpb = '0;
        for (int i = 0; i < 8; i++) begin
            nvb[i] = m_nvb[i];
            cib[i] = m_cib[i][3:0];
        end
        for (int i = 0; i < 16; i++) rpb[i] = (i < 5) ? m_rpb[i][3:0] : 4'd8;
    endtask

    task automatic set_exp_main();
        clear_exp();
        for (int i = 0; i < 11; i++) begin
            exp_nv[i] = e_nv[i];
            exp_ci[i] = e_ci[i][3:0];
        end
        for (int i = 0; i < 5; i++) exp_rp[i] = e_rp[i][3:0];
    endtask

    // Reference: dense accumulate each output row, then list its touched columns in ascending order.
    task automatic model();
        logic [31:0] acc [16];
        bit          fl  [16];
        int          p = 0;
        clear_exp();
        for (int r = 0; r < int'(rows_a); r++) begin
            for (int c = 0; c < 16; c++) begin acc[c] = '0; fl[c] = 0; end
            for (int k = int'(rpa[r]); k < int'(rpa[r+1]); k++) begin
                int j = int'(cia[k]);
                for (int l = int'(rpb[j]); l < int'(rpb[j+1]); l++) begin
                    acc[cib[l]] = acc[cib[l]] + nva[k] * nvb[l];
                    fl[cib[l]]  = 1;
                end
            end
            for (int c = 0; c < 16; c++) begin
                if (fl[c] && p < 15) begin
                    exp_nv[p] = acc[c];
                    exp_ci[p] = 4'(c);
                    p++;
                end
            end
            exp_rp[r+1] = 4'(p);
        end
    endtask

    task automatic run_op(input int mid_start, output int l, output bit pc);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        l  = 0;
        pc = 0;
        while (op_complete !== 1'b1 && l < 200) begin
            pc    = computing;
            start = (l == mid_start);
            @(negedge clk);
            l++;
        end
        start = 1'b0;
        check("op_complete", l, {31'd0, op_complete}, 32'd1);
        check("computing_at_done", l, {31'd0, computing}, 32'd0);
    endtask

    task automatic rand_case();
        int p;
        nva = '0; cia = '0; nvb = '0; cib = '0;
        for (int i = 0; i < 16; i++) begin
            nva[i] = $urandom; nvb[i] = $urandom;
            cia[i] = 4'($urandom_range(0, 3)); cib[i] = 4'($urandom_range(0, 3));
        end
        p = 0;
        rpb[0] = 0;
        for (int j = 0; j < 4; j++) begin
            int n = 0;
            for (int c = 0; c < 4; c++) begin
                if (n < 3 && $urandom_range(0, 2) == 0) begin
                    cib[p] = 4'(c);
                    nvb[p] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 20));
                    p++; n++;
                end
            end
            rpb[j+1] = 4'(p);
        end
        for (int i = 5; i < 16; i++) rpb[i] = 4'(p);
        rows_a = 4'($urandom_range(1, 3));
        p = 0;
        rpa[0] = 0;
        for (int r = 0; r < int'(rows_a); r++) begin
            int n = 0;
            for (int c = 0; c < 4; c++) begin
                if (n < 3 && $urandom_range(0, 1) == 0) begin
                    cia[p] = 4'(c);
                    nva[p] = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 20));
                    p++; n++;
                end
            end
            rpa[r+1] = 4'(p);
        end
        for (int i = int'(rows_a) + 1; i < 16; i++) rpa[i] = 4'(p);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rows_a = '0;
        nva = '0; cia = '0; rpa = '0; nvb = '0; cib = '0; rpb = '0;
        @(negedge clk);
        @(negedge clk) rst = 1'b0;
        clear_exp();
        check_all("reset");
        check("reset.computing", 0, {31'd0, computing}, 32'd0);
        check("reset.op_complete", 0, {31'd0, op_complete}, 32'd0);

        load_main_a(); load_main_b();
        run_op(-1, lat, prevc);
        check("main.latency_le_40", 0, {31'd0, lat <= 40}, 32'd1);
        check("main.computing_fall", 0, {31'd0, prevc}, 32'd1);
        set_exp_main();
        check_all("main");
        repeat (3) @(negedge clk);
        check_all("main_hold");
        check("main_hold.op_complete", 0, {31'd0, op_complete}, 32'd1);

        nvb = '0; cib = '0; rpb = '0;
        for (int i = 0; i < 4; i++) begin nvb[i] = 32'd1; cib[i] = 4'(i); end
        for (int i = 0; i < 16; i++) rpb[i] = (i < 5) ? 4'(i) : 4'd4;
        run_op(-1, lat, prevc);
        clear_exp();
        for (int i = 0; i < 7; i++) begin exp_nv[i] = nva[i]; exp_ci[i] = cia[i]; end
        for (int i = 0; i < 5; i++) exp_rp[i] = rpa[i];
        check_all("identity");

        load_main_b();
        nva = '0; cia = '0; rpa = '0;
        nva[0] = 32'd5; cia[0] = 4'd1;
        nva[1] = 32'd3; cia[1] = 4'd0;
        for (int i = 0; i < 16; i++) rpa[i] = (i == 0) ? 4'd0 : ((i == 1) ? 4'd1 : 4'd2);
        rows_a = 4'd2;
        run_op(-1, lat, prevc);
        model();
        check("zero_row.rpc1", 1, {28'd0, rpc[1]}, 32'd0);
        check_all("zero_row");

        rows_a = 4'd0;
        run_op(-1, lat, prevc);
        check("rows0.latency", 0, lat, 0);
        clear_exp();
        check_all("rows0");

        load_main_a(); load_main_b();
        run_op(10, lat, prevc);
        set_exp_main();
        check_all("mid_start");

        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (17) @(negedge clk);
        check("pre_reset.computing", 0, {31'd0, computing}, 32'd1);
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        clear_exp();
        check_all("mid_reset");
        check("mid_reset.computing", 0, {31'd0, computing}, 32'd0);
        check("mid_reset.op_complete", 0, {31'd0, op_complete}, 32'd0);
        run_op(-1, lat, prevc);
        set_exp_main();
        check_all("after_reset");

        for (int t = 0; t < 25; t++) begin
            rand_case();
            run_op(-1, lat, prevc);
            model();
            check_all("random");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
